// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - FIFO-draining UART transmitter, 8N1 (8E1 with `UART_TX_PARITY_EN)
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    output logic       fifo_pop,
    input  logic [7:0] fifo_data,
    output logic       tx,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n, pop_n, busy_n;
    logic          wrap;
    logic [2:0]    bit_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            fifo_pop <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            tx       <= tx_n;
            fifo_pop <= pop_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        tx_n    = tx;
        pop_n   = 1'b0;
        wrap    = (cnt == CNT_MAX);
        bit_inc = bit_idx + 3'd1;

        case (state)
            IDLE: begin
                tx_n  = 1'b1;
                cnt_n = '0;
                if (enable && !fifo_empty) begin
                    pop_n   = 1'b1;
                    state_n = LOAD;
                end
            end
            // FIFO pops on the falling edge inside this cycle, so fifo_data is valid here
            LOAD: begin
                shift_n = fifo_data;
                tx_n    = 1'b0;
                cnt_n   = '0;
                state_n = START;
            end
            START: begin
                cnt_n = wrap ? '0 : cnt + CW'(1);
                if (wrap) begin
                    tx_n    = shift[0];
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                cnt_n = wrap ? '0 : cnt + CW'(1);
                if (wrap) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_n    = ^shift;
                        state_n = PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_inc;
                        tx_n  = shift[bit_inc];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                cnt_n = wrap ? '0 : cnt + CW'(1);
                if (wrap) begin
                    tx_n    = 1'b1;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                cnt_n = wrap ? '0 : cnt + CW'(1);
                tx_n  = 1'b1;
                if (wrap) begin
                    state_n = IDLE;
                end
            end
            default: begin
                tx_n    = 1'b1;
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - randomized self-checking bench for uart_tx_drain against a frame-level model
module tb_uart_tx_drain;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_pop;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    uart_tx_drain #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_data  (fifo_data),
        .tx         (tx),
        .busy       (busy)
    );

    logic [7:0]  fq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_start = -1;
    int          m_end = -1;
    logic [7:0]  m_byte = 8'h00;
    int          pop_count = 0;
    int          busy_cnt = 0;
    logic [10:0] slots = '0;
    int          pop_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Line level of frame slot k for byte b: start, LSB-first data, [even parity], stop
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic step();
        logic en_e, emp_e, rst_e, exp_pop, exp_tx, exp_busy;
        int k;
        en_e  = enable;
        emp_e = fifo_empty;
        rst_e = reset;
        @(negedge clk);
        cyc++;
        exp_pop = rst_e && reset && en_e && !emp_e && (cyc - 1 > m_end);
        if (exp_pop) begin
            m_start = cyc;
            m_end   = cyc + F * N;
            m_byte  = fq[0];
        end
        exp_busy = reset && (cyc <= m_end);
        exp_tx   = 1'b1;
        if (reset && cyc > m_start && cyc <= m_end) begin
            k      = (cyc - m_start - 1) / N;
            exp_tx = frame_bit(m_byte, k);
            if ((cyc - m_start - 1) % N == N / 2) slots[k] = tx;
        end
        check("pop", fifo_pop, exp_pop);
        check("tx", tx, exp_tx);
        check("busy", busy, exp_busy);
        if (busy) busy_cnt++;
        if (fifo_pop) begin
            pop_count++;
            pop_cyc.push_back(cyc);
            if (fq.size() > 0) fifo_data = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
    endtask

    task automatic run_until_idle(input int max);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (n < max && !(cyc > m_end + 2 && (fq.size() == 0 || !enable) && !busy));
        if (n >= max) check("timeout", 32'd1, 32'd0);
    endtask

    task automatic new_frame_stats();
        pop_count = 0;
        busy_cnt  = 0;
        slots     = '0;
        pop_cyc.delete();
    endtask

    initial begin
        int n;
        // reset asserted with random inputs
        #1 reset = 1'b0;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_pop", fifo_pop, 1'b0);
        check("rst_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            enable     = 1'($urandom);
            fifo_empty = 1'($urandom);
            fifo_data  = 8'($urandom);
            step();
        end
        fifo_empty = 1'b1;
        enable     = 1'b1;
        reset      = 1'b1;
        new_frame_stats();
        repeat (50) step();
        check("idle_nopop", pop_count, 0);

        // single byte 0xA5
        new_frame_stats();
        push(8'hA5);
        run_until_idle(200);
        check("a5_pops", pop_count, 1);
`ifdef UART_TX_PARITY_EN
        check("a5_slots", slots, 11'h54A);
`else
        check("a5_slots", slots, 11'h34A);
`endif
        check("a5_busy_len", busy_cnt, F * N + 1);

        // back-to-back 0x00, 0xFF
        new_frame_stats();
        push(8'h00);
        push(8'hFF);
        run_until_idle(300);
        check("b2b_pops", pop_count, 2);
        if (pop_cyc.size() == 2) check("b2b_spacing", pop_cyc[1] - pop_cyc[0], F * N + 2);
        check("b2b_empty", fifo_empty, 1'b1);
        check("b2b_busy", busy, 1'b0);

        // enable gating
        new_frame_stats();
        enable = 1'b0;
        push(8'h3C);
        repeat (30) step();
        check("gate_nopop", pop_count, 0);
        enable = 1'b1;
        n = 0;
        while (pop_count == 0 && n < 20) begin
            step();
            n++;
        end
        push(8'h55);
        repeat (10) step();
        enable = 1'b0;
        run_until_idle(200);
        check("gate_pops", pop_count, 1);
        check("gate_left", fq.size(), 1);

        // reset during data bit 3 of 0x55
        new_frame_stats();
        enable = 1'b1;
        n = 0;
        while (!(pop_count >= 1 && cyc >= m_start + 1 + 4 * N + 1) && n < 200) begin
            step();
            n++;
        end
        check("mid_tx_low", tx, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        m_start = -1;
        m_end   = -1;
        push(8'h81);
        repeat (2) step();
        reset = 1'b1;
        new_frame_stats();
        run_until_idle(200);
        check("mid_repop", pop_count, 1);
        check("mid_busy_len", busy_cnt, F * N + 1);

        // parity-sensitive bytes
        new_frame_stats();
        push(8'h07);
        run_until_idle(200);
        check("p07_slot9", slots[9], 1'b1);
        check("p07_len", busy_cnt, F * N + 1);
        new_frame_stats();
        push(8'h03);
        run_until_idle(200);
`ifdef UART_TX_PARITY_EN
        check("p03_slot9", slots[9], 1'b0);
`else
        check("p03_slot9", slots[9], 1'b1);
`endif
        check("p03_len", busy_cnt, F * N + 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0 && fq.size() < 4) push(8'($urandom));
            enable = ($urandom_range(9) != 0);
            step();
        end
        enable = 1'b1;
        run_until_idle(1000);
        check("final_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- Serial transmit stage directly downstream of the 8-bit byte FIFO.
- Pops one byte whenever the FIFO is non-empty and transmission is enabled.
- Serialises each byte as a standard 8N1 UART frame on the tx pin. Framing is 8E1 when the parity option is compiled in.
- Single clock domain, shared with the FIFO.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200). Legal range 2..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  high = allowed to start new frames
- fifo_empty  input  1  FIFO empty flag
- fifo_pop  output  1  pop strobe to FIFO
- fifo_data  input  8  FIFO data_out
- tx  output  1  UART serial line, idle high
- busy  output  1  high while a frame is being fetched or sent

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, tx=1, fifo_pop=0, busy=0, baud counter=0, bit index=0, shift register=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Baud counter width: $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and then wraps. Each wrap ends one bit period.
- busy = (state != IDLE).
- State IDLE:
  - tx=1.
  - At a rising edge with enable=1 and fifo_empty=0: fifo_pop<=1, state<=LOAD.
  - Otherwise remain in IDLE.
- State LOAD (exactly one cycle):
  - fifo_pop is high for this whole cycle. The FIFO acts on its falling edge, so fifo_data is valid by the next rising edge.
  - At that rising edge: shift<=fifo_data, fifo_pop<=0, tx<=0, counter<=0, state<=START.
- State START:
  - tx=0 for CLKS_PER_BIT cycles.
  - Then: tx<=shift[0], bit index<=0, state<=DATA.
- State DATA:
  - Bits are sent LSB first, each held for CLKS_PER_BIT cycles.
  - After bit 7: state<=STOP, tx<=1. With the parity option, go to PARITY instead.
- State STOP:
  - tx=1 for CLKS_PER_BIT cycles, then state<=IDLE.
- fifo_pop is high for exactly one cycle per frame and is never asserted outside LOAD.
- Back-to-back frames: the next pop can issue on the first IDLE edge. The inter-frame gap is therefore the stop bit plus 2 idle-high cycles (IDLE + LOAD).
- fifo_empty is sampled only in IDLE; once LOAD is entered, the byte is committed.
- enable deasserted mid-frame: the current frame completes normally; no further pop occurs.
- reset asserted mid-frame: the frame is aborted, tx returns to 1 immediately, and no partial pop is retried.
- fifo_empty and enable are not sampled outside IDLE.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP.
  - tx = even parity of the 8 data bits (XOR reduction), held for CLKS_PER_BIT cycles.
  - Frame length is 11 bit periods.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame length is 10 bit periods (8N1).

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> tx=1, fifo_pop=0, busy=0 throughout. After release with fifo_empty=1, no pop for 50 cycles.
- Single byte (CLKS_PER_BIT=4): fifo holds 0xA5, enable=1.
  - fifo_pop high for exactly 1 cycle.
  - tx sequence per 4-cycle slot: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 0xA5, stop).
  - busy falls after 40 cycles of frame.
- Back-to-back: fifo holds 0x00 then 0xFF -> two frames with exactly 2 idle-high cycles between stop and next start; exactly 2 pops total; then fifo_empty=1 and IDLE.
- enable gating: enable=0 with fifo non-empty -> no pop. Drop enable mid-frame of 0x3C -> frame completes intact, no second pop.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1 within the same cycle (async). After release the next non-empty condition causes a fresh pop and a full frame.
- With UART_TX_PARITY_EN:
  - Byte 0x07 -> parity bit 1. Byte 0x03 -> parity bit 0.
  - Frame is 11 slots long.
  - Without the macro, the same bytes give 10-slot frames.
